// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Holds the data width, state encoding and underrun fill byte.
package spi_pkg;

    localparam int SPI_DW = 8;
    localparam int SPI_CW = $clog2(SPI_DW);

    localparam logic [SPI_DW-1:0] DEFAULT_TX_C = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin.
// Emits one-cycle rise and fall strobes in the clk domain.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              dly;

    // Shift the pin through the synchroniser and keep one extra history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{INIT}};
            dly  <= INIT;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            dly  <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~dly;
    assign fall = ~sync[STAGES-1] & dly;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder, MSB first, oversampled in the clk domain.
// Optional status flags are built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [SPI_DW-1:0] DEFAULT_TX  = DEFAULT_TX_C
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic              rxack,
    input  logic              clr_err,
    output logic              rxfull,
    output logic              rx_overrun,
    output logic              tx_underrun,
`endif
    input  logic              sclk,
    input  logic              ssn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [SPI_DW-1:0] txdin,
    input  logic              txload,
    output logic              txrdy,
    output logic [SPI_DW-1:0] rxdout,
    output logic              rxvalid,
    output logic              busy
);

    logic sclk_rise, sclk_fall;
    logic ssn_rise, ssn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_state_t        state;
    logic [SPI_CW-1:0] bit_cnt;
    logic [SPI_DW-1:0] shift_in;
    logic [SPI_DW-1:0] shift_out;
    logic [SPI_DW-1:0] hold;
    logic              reload;
    logic              rx_done;

    logic              load_evt;
    logic [SPI_DW-1:0] load_val;
    logic              hold_wr;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk (clk),
        .rst (rst),
        .din (sclk),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ssn (
        .clk (clk),
        .rst (rst),
        .din (ssn),
        .rise(ssn_rise),
        .fall(ssn_fall)
    );

    // MOSI only needs its level, so it gets a plain synchroniser
    always_ff @(posedge clk) begin
        if (rst) mosi_sync <= '1;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Holding-to-shift transfer happens at select and after each finished byte
    always_comb begin
        load_evt = 1'b0;
        if (!ssn_rise) begin
            if (state == IDLE && ssn_fall)
                load_evt = 1'b1;
            if (state == SEL && sclk_fall && reload)
                load_evt = 1'b1;
        end
        load_val = txrdy ? DEFAULT_TX : hold;
        hold_wr  = txload && (txrdy || load_evt);
    end

    // Transfer state machine with registered pin and byte outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            hold      <= '0;
            reload    <= 1'b0;
            rx_done   <= 1'b0;
            txrdy     <= 1'b1;
            rxdout    <= '0;
            rxvalid   <= 1'b0;
            busy      <= 1'b0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rxvalid <= rx_done;
            if (hold_wr) begin
                hold  <= txdin;
                txrdy <= 1'b0;
            end else if (load_evt && !txrdy) begin
                txrdy <= 1'b1;
            end
            if (ssn_rise) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                shift_in <= '0;
                reload   <= 1'b0;
                busy     <= 1'b0;
                miso     <= 1'b1;
                miso_oe  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ssn_fall) begin
                            state     <= SEL;
                            miso_oe   <= 1'b1;
                            shift_out <= load_val;
                            miso      <= load_val[SPI_DW-1];
                        end
                    end
                    SEL, SHIFT: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[SPI_DW-2:0], mosi_s};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == SPI_CW'(SPI_DW - 1)) begin
                                rxdout  <= {shift_in[SPI_DW-2:0], mosi_s};
                                rx_done <= 1'b1;
                                state   <= SEL;
                                busy    <= 1'b0;
                                reload  <= 1'b1;
                            end else begin
                                state <= SHIFT;
                                busy  <= 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (state == SHIFT) begin
                                shift_out <= {shift_out[SPI_DW-2:0], 1'b0};
                                miso      <= shift_out[SPI_DW-2];
                            end else if (reload) begin
                                shift_out <= load_val;
                                miso      <= load_val[SPI_DW-1];
                                reload    <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    // Receive-full and sticky error flags; a new byte beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            rxfull      <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (rx_done)    rxfull <= 1'b1;
            else if (rxack) rxfull <= 1'b0;
            if (clr_err) begin
                rx_overrun  <= 1'b0;
                tx_underrun <= 1'b0;
            end
            if (rx_done && rxfull)  rx_overrun  <= 1'b1;
            if (load_evt && txrdy)  tx_underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx acting as an SPI mode-0 master.
// Status checks are added when SPI_SLAVE_STATUS_EN is defined.
module tb_spi_slave_rx_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       ssn = 1'b1;
    logic       mosi = 1'b1;
    logic       miso, miso_oe;
    logic [7:0] txdin = 8'h00;
    logic       txload = 1'b0;
    logic       txrdy;
    logic [7:0] rxdout;
    logic       rxvalid;
    logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       rxack = 1'b0;
    logic       clr_err = 1'b0;
    logic       rxfull, rx_overrun, tx_underrun;
`endif

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    logic [7:0] got;

    always #5 clk = ~clk;

    spi_slave_rx_tx dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SPI_SLAVE_STATUS_EN
        .rxack      (rxack),
        .clr_err    (clr_err),
        .rxfull     (rxfull),
        .rx_overrun (rx_overrun),
        .tx_underrun(tx_underrun),
`endif
        .sclk       (sclk),
        .ssn        (ssn),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .txdin      (txdin),
        .txload     (txload),
        .txrdy      (txrdy),
        .rxdout     (rxdout),
        .rxvalid    (rxvalid),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (rxvalid === 1'b1) rx_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] d);
        txdin  = d;
        txload = 1'b1;
        tick(1);
        txload = 1'b0;
    endtask

    task automatic sel();
        ssn = 1'b0;
        tick(8);
    endtask

    task automatic desel();
        ssn = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(8);
            rx[7-i] = miso;
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
        tick(8);
    endtask

    initial begin
        // 1: reset values, loaded byte, first transfer
        tick(3);
        chk("rst_miso", miso, 1);
        chk("rst_oe", miso_oe, 0);
        chk("rst_txrdy", txrdy, 1);
        chk("rst_rxdout", rxdout, 8'h00);
        chk("rst_rxvalid", rxvalid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);
        load(8'hA5);
        chk("t1_txrdy_ld", txrdy, 0);
        sel();
        chk("t1_oe", miso_oe, 1);
        chk("t1_txrdy_sel", txrdy, 1);
        xfer(8'h3C, 8, got);
        chk("t1_miso", got, 8'hA5);
        chk("t1_rxdout", rxdout, 8'h3C);
        chk("t1_rxcnt", rx_cnt, 1);
        desel();
        chk("t1_oe_off", miso_oe, 0);

        // 2: underrun sends the fill byte
        sel();
        xfer(8'h81, 8, got);
        chk("t2_miso", got, 8'hFF);
        chk("t2_rxdout", rxdout, 8'h81);
        chk("t2_rxcnt", rx_cnt, 2);
        desel();

        // 3: two-byte burst, second byte loaded during the burst
        load(8'h12);
        sel();
        load(8'h34);
        chk("t3_txrdy", txrdy, 0);
        xfer(8'h5A, 8, got);
        chk("t3_miso0", got, 8'h12);
        chk("t3_rx0", rxdout, 8'h5A);
        chk("t3_cnt0", rx_cnt, 3);
        xfer(8'hA6, 8, got);
        chk("t3_miso1", got, 8'h34);
        chk("t3_rx1", rxdout, 8'hA6);
        chk("t3_cnt1", rx_cnt, 4);
        desel();

        // 4: aborted partial byte, then a clean byte
        sel();
        xfer(8'hF0, 5, got);
        chk("t4_busy", busy, 1);
        desel();
        chk("t4_rxcnt", rx_cnt, 4);
        chk("t4_rxdout", rxdout, 8'hA6);
        chk("t4_busy_off", busy, 0);
        chk("t4_miso", miso, 1);
        sel();
        xfer(8'hC3, 8, got);
        chk("t4_rx", rxdout, 8'hC3);
        chk("t4_rxcnt2", rx_cnt, 5);
        desel();

        // 5: reset mid-byte drops everything including the held byte
        sel();
        load(8'h77);
        chk("t5_txrdy_ld", txrdy, 0);
        xfer(8'h99, 3, got);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        ssn = 1'b1;
        tick(1);
        chk("t5_miso", miso, 1);
        chk("t5_oe", miso_oe, 0);
        chk("t5_txrdy", txrdy, 1);
        chk("t5_busy_off", busy, 0);
        chk("t5_rxdout", rxdout, 8'h00);
        chk("t5_rxvalid", rxvalid, 0);
        rst = 1'b0;
        tick(8);
        sel();
        xfer(8'hE7, 8, got);
        chk("t5_miso2", got, 8'hFF);
        chk("t5_rx2", rxdout, 8'hE7);
        chk("t5_rxcnt", rx_cnt, 6);
        desel();

`ifdef SPI_SLAVE_STATUS_EN
        // 6: rxfull, overrun and underrun flags
        clr_err = 1'b1;
        rxack = 1'b1;
        tick(1);
        clr_err = 1'b0;
        rxack = 1'b0;
        chk("t6_full0", rxfull, 0);
        chk("t6_ov0", rx_overrun, 0);
        chk("t6_un0", tx_underrun, 0);
        load(8'h55);
        sel();
        chk("t6_un_sel", tx_underrun, 0);
        xfer(8'h11, 8, got);
        chk("t6_miso0", got, 8'h55);
        chk("t6_full1", rxfull, 1);
        chk("t6_ov1", rx_overrun, 0);
        xfer(8'h22, 8, got);
        chk("t6_miso1", got, 8'hFF);
        chk("t6_rx1", rxdout, 8'h22);
        chk("t6_ov2", rx_overrun, 1);
        chk("t6_un2", tx_underrun, 1);
        desel();
        clr_err = 1'b1;
        rxack = 1'b1;
        tick(1);
        clr_err = 1'b0;
        rxack = 1'b0;
        chk("t6_ov_clr", rx_overrun, 0);
        chk("t6_un_clr", tx_underrun, 0);
        chk("t6_full_clr", rxfull, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
